// File: rtl/mio_bus_if.sv
// CPU-side and slave-side signals of the MIO bus controller.
// master: the controller, which drives the slave windows and answers the CPU.
// slave : the environment, meaning the CPU data port plus the slave windows.
interface mio_bus_if #(
  parameter int unsigned NSLV   = 4,
  parameter int unsigned DATA_W = 32
);
  logic                     cpu_req;
  logic                     cpu_we;
  logic [31:0]              cpu_addr;
  logic [DATA_W-1:0]        cpu_wdata;
  logic [DATA_W-1:0]        cpu_rdata;
  logic                     cpu_ready;
  logic                     cpu_err;
  logic [NSLV-1:0]          slv_sel;
  logic                     slv_we;
  logic [31:0]              slv_addr;
  logic [DATA_W-1:0]        slv_wdata;
  logic [NSLV*DATA_W-1:0]   slv_rdata;
  logic [NSLV-1:0]          slv_ack;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_rdata, slv_ack,
    output cpu_rdata, cpu_ready, cpu_err, slv_sel, slv_we, slv_addr, slv_wdata
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_rdata, slv_ack,
    input  cpu_rdata, cpu_ready, cpu_err, slv_sel, slv_we, slv_addr, slv_wdata
  );
endinterface

// File: rtl/mio_bus_ctrl.sv
// Handshaked MIO bus controller: decodes the address nibble to a slave window,
// waits for that slave's ack (or a timeout), then returns a one-cycle ready.
module mio_bus_ctrl #(
  parameter int unsigned          NSLV     = 4,
  parameter int unsigned          DATA_W   = 32,
  parameter logic [NSLV*4-1:0]    SLV_BASE = {4'hf, 4'he, 4'hd, 4'h0},
  parameter int unsigned          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  mio_bus_if.master   bus,
  output logic        busy,
  output logic [7:0]  err_count
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_hit;
  logic [NSLV-1:0]   w_sel;
  logic              w_ack;
  logic [DATA_W-1:0] w_rdata;

  // Address decode: first (lowest-index) window whose base nibble matches wins.
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (!w_hit && (bus.cpu_addr[31:28] == SLV_BASE[4*i +: 4])) begin
        w_hit    = 1'b1;
        w_sel[i] = 1'b1;
      end
    end
  end

  // Ack and read data of the selected slave only; other slaves are masked off.
  always_comb begin
    w_ack   = |(bus.slv_ack & bus.slv_sel);
    w_rdata = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (bus.slv_sel[i]) begin
        w_rdata = w_rdata | bus.slv_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Transaction FSM with all bus outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      busy          <= 1'b0;
      err_count     <= 8'h00;
      bus.cpu_rdata <= '0;
      bus.cpu_ready <= 1'b0;
      bus.cpu_err   <= 1'b0;
      bus.slv_sel   <= '0;
      bus.slv_we    <= 1'b0;
      bus.slv_addr  <= '0;
      bus.slv_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cpu_req) begin
            bus.slv_addr  <= bus.cpu_addr;
            bus.slv_wdata <= bus.cpu_wdata;
            busy          <= 1'b1;
            if (w_hit) begin
              r_state     <= S_ACCESS;
              r_cnt       <= '0;
              bus.slv_sel <= w_sel;
              bus.slv_we  <= bus.cpu_we;
            end else begin
              // Unmapped address: answer immediately with an error.
              r_state       <= S_RESP;
              bus.cpu_ready <= 1'b1;
              bus.cpu_err   <= 1'b1;
              bus.cpu_rdata <= '0;
            end
          end
        end

        S_ACCESS: begin
          if (w_ack) begin
            r_state       <= S_RESP;
            bus.cpu_ready <= 1'b1;
            bus.cpu_err   <= 1'b0;
            bus.cpu_rdata <= bus.slv_we ? '0 : w_rdata;
            bus.slv_sel   <= '0;
            bus.slv_we    <= 1'b0;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_state       <= S_RESP;
            bus.cpu_ready <= 1'b1;
            bus.cpu_err   <= 1'b1;
            bus.cpu_rdata <= '0;
            bus.slv_sel   <= '0;
            bus.slv_we    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_RESP: begin
          r_state       <= S_IDLE;
          busy          <= 1'b0;
          bus.cpu_ready <= 1'b0;
          bus.cpu_err   <= 1'b0;
          if (bus.cpu_err && (err_count != 8'hff)) begin
            err_count <= err_count + 8'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Bench for mio_bus_ctrl: a transaction-level model predicts every cycle of
// each access; a negedge compare process checks the DUT against it.
module tb_mio_bus_ctrl;

  localparam int unsigned NSLV = 4;
  localparam int unsigned DW   = 32;
  localparam int unsigned TO   = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       busy;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  mio_bus_if #(.NSLV(NSLV), .DATA_W(DW)) bus ();

  mio_bus_ctrl #(
    .NSLV(NSLV), .DATA_W(DW), .SLV_BASE({4'hf, 4'he, 4'hd, 4'h0}), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .err_count(err_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave windows: each acks once it has been selected for t_delay cycles;
  // t_noise forces acks on windows that are not being addressed.
  logic [DW-1:0]   sdata [NSLV];
  logic [3:0]      BASE  [NSLV] = '{4'h0, 4'hd, 4'he, 4'hf};
  int              t_delay = 0;
  logic [NSLV-1:0] t_noise = '0;
  int              acc_cnt = 0;

  always @(posedge clk) acc_cnt <= (bus.slv_sel != '0) ? acc_cnt + 1 : 0;

  always_comb begin
    for (int i = 0; i < NSLV; i++) begin
      bus.slv_ack[i]           = (bus.slv_sel[i] && (acc_cnt >= t_delay)) || t_noise[i];
      bus.slv_rdata[i*DW +: DW] = sdata[i];
    end
  end

  // Expected value of the observable outputs for one cycle.
  typedef struct {
    logic [NSLV-1:0] sel;
    logic            we;
    logic            ready;
    logic            err;
    logic            busy;
    logic [DW-1:0]   rdata;
    logic [7:0]      ecnt;
    logic [31:0]     addr;
    logic [DW-1:0]   wdata;
  } exp_t;

  exp_t          q[$];
  exp_t          ce;
  logic [DW-1:0] m_rdata = '0;
  logic [7:0]    m_ecnt  = 8'h00;
  bit            run     = 1'b0;
  int            cyc = 0, t_launch = 0, n_launch = 0, seen_launch = 0;
  int            last_lat = -1, sel_cycles = 0, we_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t idle_e();
    exp_t e;
    e.sel = '0; e.we = 1'b0; e.ready = 1'b0; e.err = 1'b0; e.busy = 1'b0;
    e.rdata = m_rdata; e.ecnt = m_ecnt; e.addr = '0; e.wdata = '0;
    return e;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hff) ? 8'hff : v + 8'd1;
  endfunction

  // Start an access (call at negedge+1 so the next rising edge samples it)
  // and predict its whole cycle-by-cycle outcome, ending in one IDLE cycle.
  // Returns at negedge+1 of that IDLE cycle with cpu_req still high.
  task automatic launch(input logic [31:0] addr, input logic we, input logic [DW-1:0] wdata,
                        input int delay, input logic [NSLV-1:0] noise);
    int   idx, nacc, len;
    bit   to;
    exp_t e;
    idx = -1;
    for (int i = 0; i < NSLV; i++) if (idx < 0 && BASE[i] == addr[31:28]) idx = i;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    t_delay = delay; t_noise = noise; t_launch = cyc; n_launch++;
    if (idx < 0) begin
      e = idle_e(); e.busy = 1'b1; e.ready = 1'b1; e.err = 1'b1; e.rdata = '0;
      q.push_back(e);
      m_rdata = '0;
      m_ecnt  = sat_inc(m_ecnt);
      len = 2;
    end else begin
      to   = (delay >= int'(TO));
      nacc = to ? int'(TO) : delay + 1;
      e = idle_e(); e.sel[idx] = 1'b1; e.we = we; e.busy = 1'b1; e.addr = addr; e.wdata = wdata;
      repeat (nacc) q.push_back(e);
      m_rdata = (to || we) ? '0 : sdata[idx];
      e = idle_e(); e.busy = 1'b1; e.ready = 1'b1; e.err = to;
      q.push_back(e);
      if (to) m_ecnt = sat_inc(m_ecnt);
      len = nacc + 2;
    end
    q.push_back(idle_e());
    @(negedge clk); #1;
    // Garble the CPU inputs while the access runs; the DUT must use its latched copy.
    bus.cpu_addr = $urandom; bus.cpu_wdata = $urandom; bus.cpu_we = 1'($urandom);
    repeat (len - 1) @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.cpu_req = 1'b0;
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Per-cycle comparison against the model, plus latency bookkeeping.
  always @(negedge clk) begin
    if (run) begin
      ce = (q.size() > 0) ? q.pop_front() : idle_e();
      if (seen_launch != n_launch) begin
        seen_launch = n_launch; sel_cycles = 0; we_cycles = 0;
      end
      chk("slv_sel",   64'(bus.slv_sel),   64'(ce.sel));
      chk("slv_we",    64'(bus.slv_we),    64'(ce.we));
      chk("cpu_ready", 64'(bus.cpu_ready), 64'(ce.ready));
      chk("cpu_err",   64'(bus.cpu_err),   64'(ce.err));
      chk("cpu_rdata", 64'(bus.cpu_rdata), 64'(ce.rdata));
      chk("busy",      64'(busy),          64'(ce.busy));
      chk("err_count", 64'(err_count),     64'(ce.ecnt));
      if (ce.sel != '0) begin
        chk("slv_addr",  64'(bus.slv_addr),  64'(ce.addr));
        chk("slv_wdata", 64'(bus.slv_wdata), 64'(ce.wdata));
      end
      if (bus.slv_sel != '0) sel_cycles++;
      if (bus.slv_we) we_cycles++;
      if (bus.cpu_ready) last_lat = cyc - t_launch;
    end
  end

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    for (int i = 0; i < NSLV; i++) sdata[i] = 32'h5000_0000 + 32'(i);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_sel",   64'(bus.slv_sel),   64'h0);
    chk("rst_ready", 64'(bus.cpu_ready), 64'h0);
    chk("rst_rdata", 64'(bus.cpu_rdata), 64'h0);
    chk("rst_busy",  64'(busy),          64'h0);
    chk("rst_ecnt",  64'(err_count),     64'h0);
    #1 rst = 1'b0; run = 1'b1;
    idle(2);

    // Zero-wait read of slave 0 with other slaves acking spuriously.
    sdata[0] = 32'hDEADBEEF;
    launch(32'h0000_0010, 1'b0, 32'h0, 0, 4'b1110);
    idle(2);
    chk("t2_latency", 64'(last_lat),      64'd2);
    chk("t2_selcyc",  64'(sel_cycles),    64'd1);
    chk("t2_rdata",   64'(bus.cpu_rdata), 64'hDEADBEEF);

    // Write to slave 2 acked after three wait cycles.
    launch(32'hE000_0000, 1'b1, 32'h0000_1234, 3, 4'b1011);
    idle(2);
    chk("t3_latency", 64'(last_lat),      64'd5);
    chk("t3_wecyc",   64'(we_cycles),     64'd4);
    chk("t3_rdata",   64'(bus.cpu_rdata), 64'h0);

    // Unmapped read.
    launch(32'hA000_0000, 1'b0, 32'h0, 0, 4'b0000);
    idle(2);
    chk("t4_latency", 64'(last_lat),   64'd1);
    chk("t4_selcyc",  64'(sel_cycles), 64'd0);
    chk("t4_ecnt",    64'(err_count),  64'd1);

    // Slave 1 never acks: timeout after 16 select cycles.
    sdata[1] = 32'h5555_AAAA;
    launch(32'hD000_0000, 1'b0, 32'h0, 255, 4'b1101);
    idle(2);
    chk("t5_selcyc",  64'(sel_cycles),    64'd16);
    chk("t5_latency", 64'(last_lat),      64'd17);
    chk("t5_rdata",   64'(bus.cpu_rdata), 64'h0);
    chk("t5_ecnt",    64'(err_count),     64'd2);

    // Ack on the very last allowed cycle still completes without error.
    sdata[3] = 32'hCAFE_0003;
    launch(32'hF000_0008, 1'b0, 32'h0, 15, 4'b0000);
    idle(2);
    chk("edge_latency", 64'(last_lat),      64'd17);
    chk("edge_rdata",   64'(bus.cpu_rdata), 64'hCAFE_0003);
    chk("edge_ecnt",    64'(err_count),     64'd2);

    // Asynchronous reset in the middle of an access.
    run = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'hD000_0000; t_delay = 255; t_noise = '0;
    @(negedge clk); @(negedge clk); #1;
    chk("mid_sel_before", 64'(bus.slv_sel), 64'b0010);
    rst = 1'b1;
    #1;
    chk("mid_sel",   64'(bus.slv_sel),   64'h0);
    chk("mid_busy",  64'(busy),          64'h0);
    chk("mid_ready", 64'(bus.cpu_ready), 64'h0);
    chk("mid_rdata", 64'(bus.cpu_rdata), 64'h0);
    chk("mid_ecnt",  64'(err_count),     64'h0);
    bus.cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    q.delete(); m_rdata = '0; m_ecnt = 8'h00; run = 1'b1;
    idle(4);

    // Back-to-back reads with cpu_req held high, then error saturation.
    sdata[0] = 32'h1111_0000;
    launch(32'h0000_0100, 1'b0, 32'h0, 0, 4'b0000);
    launch(32'hF000_0004, 1'b0, 32'h0, 1, 4'b0000);
    chk("b2b_latency", 64'(last_lat),      64'd3);
    chk("b2b_rdata",   64'(bus.cpu_rdata), 64'hCAFE_0003);
    for (int i = 0; i < 300; i++) begin
      launch({4'(1 + (i % 12)), 28'(i * 4)}, 1'b0, 32'h0, 0, 4'b0000);
    end
    idle(3);
    chk("sat_ecnt", 64'(err_count), 64'hff);

    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
